sobel_stream_ctrl: RTL and testbench

SOBEL_STREAM_CTRL -- requirements
Module: sobel_stream_ctrl

---
 rtl/sobel_pkg.sv | 41 ++++
 rtl/frame_counter.sv | 32 +++
 rtl/sobel_stream_ctrl.sv | 134 +++++++++++++
 tb/tb_sobel_stream_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel stream controller.
// Holds the controller state encoding and the frame geometry helpers:
//   CM = IMAGE_DIM / PIXELS_PER_BEAT   beats per row
//   N  = IMAGE_DIM * CM                beats per frame
//   D  = CM + PIPE_LAT                 advances from input beat to result
// Counters are sized so that they can hold N + D without wrapping.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int unsigned calc_cm(input int unsigned dim, input int unsigned ppb);
        return dim / ppb;
    endfunction

    function automatic int unsigned calc_n(input int unsigned dim, input int unsigned ppb);
        return dim * calc_cm(dim, ppb);
    endfunction

    function automatic int unsigned calc_d(input int unsigned dim, input int unsigned ppb,
                                           input int unsigned lat);
        return calc_cm(dim, ppb) + lat;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned d);
        return $clog2(n + d + 1);
    endfunction

    // Geometry for the default build (16 px/beat, 512x512, 24-stage pipe).
    localparam int unsigned DEF_PPB = 16;
    localparam int unsigned DEF_DIM = 512;
    localparam int unsigned DEF_LAT = 24;
    localparam int unsigned CM      = calc_cm(DEF_DIM, DEF_PPB);
    localparam int unsigned N       = calc_n(DEF_DIM, DEF_PPB);
    localparam int unsigned D       = calc_d(DEF_DIM, DEF_PPB, DEF_LAT);

endpackage

// File: rtl/frame_counter.sv
// Up-counter with synchronous clear and enable, plus a terminal-count flag.
// Ports:
//   clk, areset  clock and asynchronous active-high reset
//   clr          synchronous clear (wins over en)
//   en           increment enable
//   count        current value
//   tc           high while count == TERMINAL
module frame_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TERMINAL = 255
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Stream controller wrapped around a Sobel filter datapath.
// Accepts one frame of N input beats, feeds them into the datapath, then
// injects zero beats to drain the row delay and pipeline, and emits exactly
// N output beats with first/last markers.
// Ports:
//   clk, areset                 clock, asynchronous active-high reset
//   s_data/s_valid/s_ready/s_last   input pixel stream
//   m_data/m_valid/m_ready/m_last/m_user  output stream (m_user = first beat)
//   dp_inp_frame/dp_out_frame   datapath input beat / datapath result
//   dp_stall                    freezes the datapath when no advance
//   dp_aresetn                  synchronous active-low datapath reset
//   busy/frame_done/len_err     status: not idle / end pulse / sticky framing error
module sobel_stream_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned PIXELS_PER_BEAT = 16,
    parameter int unsigned IMAGE_DIM       = 512,
    parameter int unsigned PIPE_LAT        = 24
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic [8*PIXELS_PER_BEAT-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_last,
    output logic [8*PIXELS_PER_BEAT-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic                         m_user,
    output logic [8*PIXELS_PER_BEAT-1:0] dp_inp_frame,
    input  logic [8*PIXELS_PER_BEAT-1:0] dp_out_frame,
    output logic                         dp_stall,
    output logic                         dp_aresetn,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         len_err
);

    localparam int unsigned FRAME_BEATS = calc_n(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int unsigned FILL_DEPTH  = calc_d(IMAGE_DIM, PIXELS_PER_BEAT, PIPE_LAT);
    localparam int unsigned CW          = cnt_width(FRAME_BEATS, FILL_DEPTH);

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BEATS - 1);
    localparam logic [CW-1:0] PIPE_D   = CW'(FILL_DEPTH);

    state_t        state;
    logic          dst_ok;
    logic          adv;
    logic          consume;
    logic          out_hs;
    logic          cnt_clr;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] adv_cnt;
    logic [CW-1:0] out_cnt;
    logic          in_tc;
    logic          adv_tc;
    logic          out_tc;

    always_comb begin
        dst_ok       = ~m_valid | m_ready;
        // Once adv_cnt hits N+D the last result is already presented; FLUSH
        // stops advancing and only waits for that beat to be accepted.
        adv          = dst_ok & (((state == ST_FEED) & s_valid) |
                                 ((state == ST_FLUSH) & ~adv_tc));
        s_ready      = (state == ST_FEED) & dst_ok;
        consume      = s_valid & s_ready;
        out_hs       = m_valid & m_ready;
        cnt_clr      = (state == ST_IDLE);
        dp_stall     = ~adv;
        dp_aresetn   = (state == ST_FEED) | (state == ST_FLUSH);
        dp_inp_frame = (state == ST_FEED) ? s_data : '0;
        m_data       = dp_out_frame;
        // Markers are qualified by m_valid so they read 0 when nothing is presented.
        m_user       = m_valid & (out_cnt == '0);
        m_last       = m_valid & out_tc;
        busy         = (state != ST_IDLE);
        frame_done   = (state == ST_DONE);
    end

    frame_counter #(.WIDTH(CW), .TERMINAL(FRAME_BEATS - 1)) u_in_cnt (
        .clk    (clk),
        .areset (areset),
        .clr    (cnt_clr),
        .en     (consume),
        .count  (in_cnt),
        .tc     (in_tc)
    );

    frame_counter #(.WIDTH(CW), .TERMINAL(FRAME_BEATS + FILL_DEPTH)) u_adv_cnt (
        .clk    (clk),
        .areset (areset),
        .clr    (cnt_clr),
        .en     (adv),
        .count  (adv_cnt),
        .tc     (adv_tc)
    );

    frame_counter #(.WIDTH(CW), .TERMINAL(FRAME_BEATS - 1)) u_out_cnt (
        .clk    (clk),
        .areset (areset),
        .clr    (cnt_clr),
        .en     (out_hs),
        .count  (out_cnt),
        .tc     (out_tc)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
            len_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:  if (s_valid) state <= ST_FEED;
                ST_FEED:  if (consume && in_tc) state <= ST_FLUSH;
                ST_FLUSH: if (out_hs && out_tc) state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
            endcase

            // adv_cnt + 1 > D, written without widening the counter.
            if (adv) begin
                m_valid <= (adv_cnt >= PIPE_D);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (consume && (s_last != (in_cnt == LAST_IDX))) begin
                len_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Self-checking bench for sobel_stream_ctrl with a 4 px/beat, 8x8 frame and a
// 3-stage pipe (16 beats per frame, fill depth 5). A stub datapath delays each
// advanced input beat so the output stream should reproduce the input frame
// in order; the bench compares against the beats it generated itself.
module tb_sobel_stream_ctrl;

    localparam int PPB     = 4;
    localparam int DIM     = 8;
    localparam int LAT     = 3;
    localparam int N       = 16;
    localparam int D       = 5;
    localparam int DW      = 8 * PPB;
    localparam int MAX_CYC = 2000;

    logic          clk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          m_user;
    logic [DW-1:0] dp_inp_frame;
    logic [DW-1:0] dp_out_frame;
    logic          dp_stall;
    logic          dp_aresetn;
    logic          busy;
    logic          frame_done;
    logic          len_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int   nout;
        int   first_mv;
        int   acc_span;
        int   nadv;
        int   done_gap;
        int   blocked;
        bit   timeout;
        bit   rst_hit;
        logic pre_len;
    } res_t;

    always #5 clk = ~clk;

    sobel_stream_ctrl #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .PIPE_LAT        (LAT)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_last       (s_last),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .m_user       (m_user),
        .dp_inp_frame (dp_inp_frame),
        .dp_out_frame (dp_out_frame),
        .dp_stall     (dp_stall),
        .dp_aresetn   (dp_aresetn),
        .busy         (busy),
        .frame_done   (frame_done),
        .len_err      (len_err)
    );

    // Stub datapath: the beat captured on an advance shows at the output once
    // D further advances have happened, i.e. when the controller raises m_valid.
    logic [DW-1:0] pipe [0:D];
    always @(posedge clk) begin
        if (!dp_aresetn) begin
            for (int i = 0; i <= D; i++) pipe[i] <= '0;
        end else if (!dp_stall) begin
            pipe[0] <= dp_inp_frame;
            for (int i = 1; i <= D; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign dp_out_frame = pipe[D];

    // Runs one frame with the given input/output acceptance rates. Checks
    // per-cycle stream rules and every output beat against the generated frame.
    task automatic drive_frame(input int sv_pct, input int mr_pct, input int last_at,
                               input int stall_at, input int rst_at, output res_t r);
        logic [DW-1:0] beats [N];
        logic [DW-1:0] prev_data;
        int  n_in, n_out, n_adv, cyc, stall_left, acc0, last_hs;
        bit  done, stall_used, prev_hold, in_hs, out_hs, mr;
        r = '{default: 0};
        r.first_mv = -1;
        r.acc_span = -1;
        r.done_gap = -1;
        for (int i = 0; i < N; i++) beats[i] = $urandom;
        n_in = 0; n_out = 0; n_adv = 0; cyc = 0; stall_left = 0; acc0 = -1; last_hs = -1;
        done = 0; stall_used = 0; prev_hold = 0; prev_data = '0;
        while (!done && !r.rst_hit && cyc < MAX_CYC) begin
            @(negedge clk);
            s_valid = (n_in < N) && (int'($urandom_range(99)) < sv_pct);
            s_data  = (n_in < N) ? beats[n_in] : '0;
            s_last  = (n_in == last_at);
            mr = (int'($urandom_range(99)) < mr_pct);
            if (stall_at >= 0 && !stall_used && n_in == stall_at) begin
                stall_left = 7;
                stall_used = 1;
            end
            if (stall_left > 0) begin
                mr = 0;
                stall_left--;
            end
            m_ready = mr;
            if (rst_at >= 0 && n_in == rst_at) begin
                r.pre_len = len_err;
                areset = 1'b1;
                #1;
                checks++;
                if ({m_valid, m_last, m_user, s_ready, busy, frame_done, len_err, dp_aresetn, dp_stall}
                    !== 9'b000000001) begin
                    errors++;
                    $display("FAIL mid_frame_reset: outputs=%b expected=%b",
                             {m_valid, m_last, m_user, s_ready, busy, frame_done, len_err,
                              dp_aresetn, dp_stall}, 9'b000000001);
                end
                @(negedge clk);
                areset  = 1'b0;
                s_valid = 1'b0;
                r.rst_hit = 1;
            end else begin
                #1;
                in_hs  = s_valid && s_ready;
                out_hs = m_valid && m_ready;
                if (prev_hold) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== prev_data) begin
                        errors++;
                        $display("FAIL hold_stable: m_valid=%b m_data=%h expected m_valid=1 m_data=%h",
                                 m_valid, m_data, prev_data);
                    end
                end
                if (m_valid === 1'b1 && m_ready === 1'b0) begin
                    r.blocked++;
                    checks++;
                    if (s_ready !== 1'b0 || dp_stall !== 1'b1) begin
                        errors++;
                        $display("FAIL blocked_output: s_ready=%b dp_stall=%b expected 0 1",
                                 s_ready, dp_stall);
                    end
                end
                if (busy === 1'b1 && n_in < N) begin
                    checks++;
                    if (dp_inp_frame !== s_data) begin
                        errors++;
                        $display("FAIL feed_input: dp_inp_frame=%h expected %h", dp_inp_frame, s_data);
                    end
                end
                if (busy === 1'b1 && n_in == N && frame_done !== 1'b1) begin
                    checks++;
                    if (dp_inp_frame !== '0 || s_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL flush_input: dp_inp_frame=%h s_ready=%b expected 0 0",
                                 dp_inp_frame, s_ready);
                    end
                end
                if (out_hs) begin
                    checks++;
                    if (n_out >= N) begin
                        errors++;
                        $display("FAIL extra_output: beat index %0d expected at most %0d", n_out, N - 1);
                    end else if (m_data !== beats[n_out] || m_user !== 1'(n_out == 0) ||
                                 m_last !== 1'(n_out == N - 1)) begin
                        errors++;
                        $display("FAIL output_beat %0d: data=%h user=%b last=%b expected data=%h user=%b last=%b",
                                 n_out, m_data, m_user, m_last, beats[n_out],
                                 1'(n_out == 0), 1'(n_out == N - 1));
                    end
                    if (n_out == N - 1) last_hs = cyc;
                    n_out++;
                end
                if (r.first_mv < 0 && m_valid === 1'b1) r.first_mv = n_adv;
                if (dp_stall === 1'b0) n_adv++;
                if (in_hs) begin
                    if (n_in == 0) acc0 = cyc;
                    if (n_in == N - 1) r.acc_span = cyc - acc0;
                    n_in++;
                end
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
                if (frame_done === 1'b1) begin
                    done = 1;
                    r.done_gap = cyc - last_hs;
                end
                cyc++;
            end
        end
        if (done) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL done_one_cycle: busy=%b frame_done=%b expected 0 0", busy, frame_done);
            end
        end
        r.nout    = n_out;
        r.nadv    = n_adv;
        r.timeout = !done && !r.rst_hit;
    endtask

    task automatic test_reset();
        areset  = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m_valid, m_last, m_user, s_ready, busy, frame_done, len_err, dp_aresetn, dp_stall}
            !== 9'b000000001) begin
            errors++;
            $display("FAIL reset_outputs: %b expected %b",
                     {m_valid, m_last, m_user, s_ready, busy, frame_done, len_err, dp_aresetn,
                      dp_stall}, 9'b000000001);
        end
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: busy=%b m_valid=%b expected 0 0", busy, m_valid);
        end
    endtask

    task automatic test_continuous();
        res_t r;
        drive_frame(100, 100, N - 1, -1, -1, r);
        checks++;
        if (r.timeout) begin errors++; $display("FAIL cont_timeout: frame_done not seen expected within %0d cycles", MAX_CYC); end
        checks++;
        if (r.nout != N) begin errors++; $display("FAIL cont_count: outputs=%0d expected %0d", r.nout, N); end
        checks++;
        if (r.first_mv != D + 1) begin errors++; $display("FAIL cont_first_valid: advs=%0d expected %0d", r.first_mv, D + 1); end
        checks++;
        if (r.acc_span != N - 1) begin errors++; $display("FAIL cont_input_rate: span=%0d expected %0d", r.acc_span, N - 1); end
        checks++;
        if (r.nadv != N + D) begin errors++; $display("FAIL cont_adv_total: advs=%0d expected %0d", r.nadv, N + D); end
        checks++;
        if (r.done_gap != 1) begin errors++; $display("FAIL cont_done_gap: gap=%0d expected 1", r.done_gap); end
        checks++;
        if (len_err !== 1'b0) begin errors++; $display("FAIL cont_len_err: len_err=%b expected 0", len_err); end
    endtask

    task automatic test_stall();
        res_t r;
        drive_frame(100, 100, N - 1, 8, -1, r);
        checks++;
        if (r.timeout) begin errors++; $display("FAIL stall_timeout: frame_done not seen expected within %0d cycles", MAX_CYC); end
        checks++;
        if (r.nout != N) begin errors++; $display("FAIL stall_count: outputs=%0d expected %0d", r.nout, N); end
        checks++;
        if (r.blocked != 7) begin errors++; $display("FAIL stall_blocked_cycles: blocked=%0d expected 7", r.blocked); end
        checks++;
        if (r.nadv != N + D) begin errors++; $display("FAIL stall_adv_total: advs=%0d expected %0d", r.nadv, N + D); end
    endtask

    task automatic test_len_err();
        res_t r;
        drive_frame(100, 100, 9, -1, -1, r);
        checks++;
        if (r.timeout || r.nout != N) begin
            errors++;
            $display("FAIL lenerr_frame: outputs=%0d timeout=%0d expected %0d 0", r.nout, r.timeout, N);
        end
        checks++;
        if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_set: len_err=%b expected 1", len_err); end
        drive_frame(100, 100, N - 1, -1, -1, r);
        checks++;
        if (r.timeout || r.nout != N) begin
            errors++;
            $display("FAIL lenerr_next_frame: outputs=%0d timeout=%0d expected %0d 0", r.nout, r.timeout, N);
        end
        checks++;
        if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_sticky: len_err=%b expected 1", len_err); end
    endtask

    task automatic test_reset_mid_frame();
        res_t r;
        drive_frame(100, 100, 3, -1, 7, r);
        checks++;
        if (!r.rst_hit) begin errors++; $display("FAIL midrst_reached: rst_hit=%0d expected 1", r.rst_hit); end
        checks++;
        if (r.pre_len !== 1'b1) begin errors++; $display("FAIL midrst_pre_len: len_err=%b expected 1", r.pre_len); end
        #1;
        checks++;
        if (len_err !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: len_err=%b busy=%b m_valid=%b expected 0 0 0", len_err, busy, m_valid);
        end
        drive_frame(100, 100, N - 1, -1, -1, r);
        checks++;
        if (r.timeout || r.nout != N || r.done_gap != 1) begin
            errors++;
            $display("FAIL midrst_fresh_frame: outputs=%0d timeout=%0d gap=%0d expected %0d 0 1",
                     r.nout, r.timeout, r.done_gap, N);
        end
        checks++;
        if (len_err !== 1'b0) begin errors++; $display("FAIL midrst_len_err: len_err=%b expected 0", len_err); end
    endtask

    task automatic test_back_to_back();
        res_t r;
        for (int f = 0; f < 3; f++) begin
            drive_frame(50, 50, N - 1, -1, -1, r);
            checks++;
            if (r.timeout || r.nout != N) begin
                errors++;
                $display("FAIL b2b_frame%0d: outputs=%0d timeout=%0d expected %0d 0", f, r.nout, r.timeout, N);
            end
            checks++;
            if (len_err !== 1'b0) begin errors++; $display("FAIL b2b_len_err%0d: len_err=%b expected 0", f, len_err); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_continuous();
        test_stall();
        test_len_err();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
